// File: rtl/key_entry_pkg.sv
// -----------------------------------------------------------------------------
// key_entry_pkg
// Purpose : shared definitions for the keypad entry block: FSM state
//           encodings, BCD digit width, key command codes and a small
//           key classification helper.
// Contents: BCD_W, state_t (IDLE/PRESS_DB/HELD/RELEASE_DB),
//           ADD, SUB, MUL, EQ, CLR, BKSP, is_digit().
// -----------------------------------------------------------------------------
package key_entry_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  localparam logic [BCD_W-1:0] ADD  = 4'd10;
  localparam logic [BCD_W-1:0] SUB  = 4'd11;
  localparam logic [BCD_W-1:0] MUL  = 4'd12;
  localparam logic [BCD_W-1:0] EQ   = 4'd13;
  localparam logic [BCD_W-1:0] CLR  = 4'd14;
  localparam logic [BCD_W-1:0] BKSP = 4'd15;

  // Codes 0-9 are numeric digits; everything above is a command.
  function automatic logic is_digit(input logic [BCD_W-1:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/key_entry_fsm_debounce_counter.sv
// -----------------------------------------------------------------------------
// debounce_counter
// Purpose : saturating cycle counter used to qualify key press and release.
//           Counts up while i_inc is high, stops at TERMINAL and flags it.
// Ports   : i_clk   - clock (rising edge)
//           i_rst   - asynchronous active-high reset
//           i_clear - synchronous clear (has priority over i_inc)
//           i_inc   - count one more stable cycle
//           o_tc    - high while the count equals TERMINAL
// -----------------------------------------------------------------------------
module debounce_counter #(
  parameter int TERMINAL = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_tc
);

  localparam int CW = (TERMINAL < 1) ? 1 : $clog2(TERMINAL + 1);
  localparam logic [CW-1:0] TC_VAL = CW'(TERMINAL);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != TC_VAL)) begin
      // Saturate so a long stable period never wraps back to zero.
      r_count <= r_count + CW'(1);
    end
  end

  assign o_tc = (r_count == TC_VAL);

endmodule

// File: rtl/key_entry_fsm.sv
// -----------------------------------------------------------------------------
// key_entry_fsm
// Purpose : debounces keys from an upstream keyboard controller and builds a
//           packed-BCD operand from digit keys; command keys publish an opcode
//           with a one-cycle valid pulse. Each physical press acts once.
// Ports   : CLK        - clock, all state changes on rising edge
//           RESET      - asynchronous active-high reset
//           KeyRead    - key currently pressed
//           BCDKey     - code of the pressed key (valid while KeyRead=1)
//           Operand    - 4 packed BCD digits, newest digit in low nibble
//           DigitCount - digits entered (0..MAX_DIGITS)
//           OpCode     - last accepted command code (10..13)
//           OpValid    - one-cycle pulse when a command is accepted
//           Overflow   - sticky, set by a digit arriving when full
// Config  : define KEY_BACKSPACE_EN to make code 15 a backspace; otherwise
//           code 15 is debounced and silently consumed.
// -----------------------------------------------------------------------------
module key_entry_fsm
  import key_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_DIGITS      = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             KeyRead,
  input  logic [BCD_W-1:0] BCDKey,
  output logic [15:0]      Operand,
  output logic [2:0]       DigitCount,
  output logic [3:0]       OpCode,
  output logic             OpValid,
  output logic             Overflow
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

  state_t           r_state;
  state_t           w_state_next;
  logic [BCD_W-1:0] r_key;
  logic [15:0]      r_operand;
  logic [2:0]       r_digit_count;
  logic [3:0]       r_opcode;
  logic             r_op_valid;
  logic             r_overflow;

  logic w_capture;
  logic w_fire;
  logic w_cnt_clear;
  logic w_cnt_inc;
  logic w_cnt_tc;

  debounce_counter #(
    .TERMINAL (DEBOUNCE_CYCLES)
  ) u_debounce (
    .i_clk   (CLK),
    .i_rst   (RESET),
    .i_clear (w_cnt_clear),
    .i_inc   (w_cnt_inc),
    .o_tc    (w_cnt_tc)
  );

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and control decode
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_fire       = 1'b0;
    w_cnt_clear  = 1'b0;
    w_cnt_inc    = 1'b0;
    case (r_state)
      IDLE: begin
        if (KeyRead) begin
          w_capture    = 1'b1;
          w_cnt_clear  = 1'b1;
          w_state_next = PRESS_DB;
        end
      end
      PRESS_DB: begin
        // A drop or a code change means the press was noise.
        if (!KeyRead || (BCDKey != r_key)) begin
          w_cnt_clear  = 1'b1;
          w_state_next = IDLE;
        end else if (w_cnt_tc) begin
          w_fire       = 1'b1;
          w_state_next = HELD;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      HELD: begin
        if (!KeyRead) begin
          w_cnt_clear  = 1'b1;
          w_state_next = RELEASE_DB;
        end
      end
      RELEASE_DB: begin
        // Bounce during release goes back to HELD so it cannot re-trigger.
        if (KeyRead) begin
          w_state_next = HELD;
        end else if (w_cnt_tc) begin
          w_state_next = IDLE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Key capture and datapath; r_key is stable for the whole debounce window
  // so the action always uses the code that was actually qualified.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_key         <= '0;
      r_operand     <= '0;
      r_digit_count <= '0;
      r_opcode      <= '0;
      r_op_valid    <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_op_valid <= 1'b0;
      if (w_capture) begin
        r_key <= BCDKey;
      end
      if (w_fire) begin
        if (is_digit(r_key)) begin
          if (r_digit_count < MAX_CNT) begin
            r_operand     <= {r_operand[11:0], r_key};
            r_digit_count <= r_digit_count + 3'd1;
          end else begin
            r_overflow <= 1'b1;
          end
        end else if (r_key == CLR) begin
          r_operand     <= '0;
          r_digit_count <= '0;
          r_overflow    <= 1'b0;
        end else if (r_key == BKSP) begin
`ifdef KEY_BACKSPACE_EN
          r_operand  <= {4'h0, r_operand[15:4]};
          r_overflow <= 1'b0;
          if (r_digit_count != 3'd0) begin
            r_digit_count <= r_digit_count - 3'd1;
          end
`else
          // Backspace disabled: key is consumed with no visible effect.
`endif
        end else begin
          r_opcode   <= r_key;
          r_op_valid <= 1'b1;
        end
      end
    end
  end

  assign Operand    = r_operand;
  assign DigitCount = r_digit_count;
  assign OpCode     = r_opcode;
  assign OpValid    = r_op_valid;
  assign Overflow   = r_overflow;

endmodule

// File: tb/tb_key_entry_fsm.sv
// -----------------------------------------------------------------------------
// tb_key_entry_fsm
// Purpose : directed self-checking bench for key_entry_fsm with default
//           parameters (DEBOUNCE_CYCLES=4, MAX_DIGITS=4).
// -----------------------------------------------------------------------------
module tb_key_entry_fsm;

  logic        CLK;
  logic        RESET;
  logic        KeyRead;
  logic [3:0]  BCDKey;
  logic [15:0] Operand;
  logic [2:0]  DigitCount;
  logic [3:0]  OpCode;
  logic        OpValid;
  logic        Overflow;

  int n_checks;
  int n_fail;
  int ov_cycles;

  key_entry_fsm #(
    .DEBOUNCE_CYCLES (4),
    .MAX_DIGITS      (4)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .KeyRead    (KeyRead),
    .BCDKey     (BCDKey),
    .Operand    (Operand),
    .DigitCount (DigitCount),
    .OpCode     (OpCode),
    .OpValid    (OpValid),
    .Overflow   (Overflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Count every cycle in which OpValid is observed high.
  always @(negedge CLK) begin
    if (OpValid === 1'b1) ov_cycles++;
  end

  task automatic press_key(input logic [3:0] code, input int hold);
    @(negedge CLK);
    BCDKey  = code;
    KeyRead = 1'b1;
    repeat (hold) @(negedge CLK);
    KeyRead = 1'b0;
    repeat (10) @(negedge CLK);
    $display("press key=%0d hold=%0d -> Operand=%h DigitCount=%0d Overflow=%0b",
             code, hold, Operand, DigitCount, Overflow);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    KeyRead = 1'b0;
    BCDKey  = 4'd0;
    RESET   = 1'b1;
    repeat (3) @(negedge CLK);
    n_checks++;
    if (Operand !== 16'h0000) begin
      n_fail++; $display("FAIL reset_operand: got %h expected 0000", Operand);
    end
    n_checks++;
    if (DigitCount !== 3'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d expected 0", DigitCount);
    end
    n_checks++;
    if (OpCode !== 4'd0 || OpValid !== 1'b0 || Overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got OpCode=%0d OpValid=%b Overflow=%b expected 0/0/0",
               OpCode, OpValid, Overflow);
    end
    RESET = 1'b0;
    @(negedge CLK);
    $display("reset: Operand=%h DigitCount=%0d", Operand, DigitCount);
  endtask

  task automatic test_digits();
    ov_cycles = 0;
    // Key 1 with exact latency: updated value visible DEBOUNCE_CYCLES+2 cycles on.
    @(negedge CLK);
    BCDKey  = 4'd1;
    KeyRead = 1'b1;
    repeat (5) @(negedge CLK);
    n_checks++;
    if (Operand !== 16'h0000) begin
      n_fail++; $display("FAIL latency_early: got %h expected 0000", Operand);
    end
    @(negedge CLK);
    n_checks++;
    if (Operand !== 16'h0001 || DigitCount !== 3'd1) begin
      n_fail++;
      $display("FAIL latency_exact: got %h/%0d expected 0001/1", Operand, DigitCount);
    end
    repeat (4) @(negedge CLK);
    KeyRead = 1'b0;
    repeat (10) @(negedge CLK);
    press_key(4'd2, 8);
    press_key(4'd3, 8);
    n_checks++;
    if (Operand !== 16'h0123) begin
      n_fail++; $display("FAIL digits_operand: got %h expected 0123", Operand);
    end
    n_checks++;
    if (DigitCount !== 3'd3) begin
      n_fail++; $display("FAIL digits_count: got %0d expected 3", DigitCount);
    end
    n_checks++;
    if (ov_cycles !== 0) begin
      n_fail++; $display("FAIL digits_opvalid: got %0d pulses expected 0", ov_cycles);
    end
  endtask

  task automatic test_glitch();
    press_key(4'd5, 2);
    n_checks++;
    if (Operand !== 16'h0123 || DigitCount !== 3'd3) begin
      n_fail++;
      $display("FAIL glitch_ignored: got %h/%0d expected 0123/3", Operand, DigitCount);
    end
    press_key(4'd5, 50);
    n_checks++;
    if (Operand !== 16'h1235 || DigitCount !== 3'd4) begin
      n_fail++;
      $display("FAIL held_once: got %h/%0d expected 1235/4", Operand, DigitCount);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    ov_cycles = 0;
    press_key(4'd9, 8);
    press_key(4'd8, 8);
    press_key(4'd7, 8);
    press_key(4'd6, 8);
    n_checks++;
    if (Overflow !== 1'b0) begin
      n_fail++; $display("FAIL overflow_early: got %b expected 0", Overflow);
    end
    press_key(4'd5, 8);
    n_checks++;
    if (Operand !== 16'h9876 || DigitCount !== 3'd4 || Overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_set: got %h/%0d/%b expected 9876/4/1",
               Operand, DigitCount, Overflow);
    end
    press_key(4'd14, 8);
    n_checks++;
    if (Operand !== 16'h0000 || DigitCount !== 3'd0 || Overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_key: got %h/%0d/%b expected 0000/0/0",
               Operand, DigitCount, Overflow);
    end
    n_checks++;
    if (ov_cycles !== 0) begin
      n_fail++; $display("FAIL clear_no_opvalid: got %0d pulses expected 0", ov_cycles);
    end
  endtask

  task automatic test_command();
    press_key(4'd4, 8);
    press_key(4'd5, 8);
    ov_cycles = 0;
    @(negedge CLK);
    BCDKey  = 4'd11;
    KeyRead = 1'b1;
    repeat (6) @(negedge CLK);
    n_checks++;
    if (OpValid !== 1'b1 || OpCode !== 4'd11) begin
      n_fail++;
      $display("FAIL cmd_pulse: got OpValid=%b OpCode=%0d expected 1/11", OpValid, OpCode);
    end
    @(negedge CLK);
    n_checks++;
    if (OpValid !== 1'b0) begin
      n_fail++; $display("FAIL cmd_pulse_end: got %b expected 0", OpValid);
    end
    repeat (6) @(negedge CLK);
    KeyRead = 1'b0;
    repeat (10) @(negedge CLK);
    $display("command key=11 -> OpCode=%0d Operand=%h pulses=%0d", OpCode, Operand, ov_cycles);
    n_checks++;
    if (ov_cycles !== 1) begin
      n_fail++; $display("FAIL cmd_single: got %0d pulses expected 1", ov_cycles);
    end
    n_checks++;
    if (Operand !== 16'h0045 || DigitCount !== 3'd2 || OpCode !== 4'd11) begin
      n_fail++;
      $display("FAIL cmd_hold: got %h/%0d/%0d expected 0045/2/11",
               Operand, DigitCount, OpCode);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    BCDKey  = 4'd4;
    KeyRead = 1'b1;
    repeat (3) @(negedge CLK);
    #2 RESET = 1'b1;
    #1;
    n_checks++;
    if (Operand !== 16'h0000 || DigitCount !== 3'd0 || OpCode !== 4'd0 ||
        OpValid !== 1'b0 || Overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: got %h/%0d/%0d/%b/%b expected all zero",
               Operand, DigitCount, OpCode, OpValid, Overflow);
    end
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    KeyRead = 1'b0;
    repeat (15) @(negedge CLK);
    $display("reset mid-debounce: Operand=%h DigitCount=%0d", Operand, DigitCount);
    n_checks++;
    if (Operand !== 16'h0000 || DigitCount !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_no_pending: got %h/%0d expected 0000/0", Operand, DigitCount);
    end
  endtask

  task automatic test_backspace();
    logic [15:0] exp_op;
    logic [2:0]  exp_cnt;
    press_key(4'd4, 8);
    press_key(4'd5, 8);
    press_key(4'd6, 8);
    n_checks++;
    if (Operand !== 16'h0456 || DigitCount !== 3'd3) begin
      n_fail++;
      $display("FAIL bksp_setup: got %h/%0d expected 0456/3", Operand, DigitCount);
    end
`ifdef KEY_BACKSPACE_EN
    exp_op  = 16'h0045;
    exp_cnt = 3'd2;
`else
    exp_op  = 16'h0456;
    exp_cnt = 3'd3;
`endif
    press_key(4'd15, 8);
    n_checks++;
    if (Operand !== exp_op || DigitCount !== exp_cnt) begin
      n_fail++;
      $display("FAIL bksp_result: got %h/%0d expected %h/%0d",
               Operand, DigitCount, exp_op, exp_cnt);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    ov_cycles = 0;
    RESET     = 1'b1;
    KeyRead   = 1'b0;
    BCDKey    = 4'd0;
    test_reset();
    test_digits();
    test_glitch();
    test_overflow();
    test_command();
    test_reset_mid();
    test_backspace();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
